// File: rtl/taxi_axi_if.sv
// taxi_axi_if: AXI4 write-channel bundle with slave and master modports
interface taxi_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int ID_W = 8,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W = 1,
  parameter int BUSER_W = 1
) ();
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic [3:0] awregion;
  logic [AWUSER_W-1:0] awuser;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic wlast;
  logic [WUSER_W-1:0] wuser;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic [BUSER_W-1:0] buser;
  logic bvalid;
  logic bready;
  modport wr_slv (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input bready
  );
  modport wr_mst (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input wready,
    input bid, bresp, buser, bvalid,
    output bready
  );
endinterface

// File: rtl/taxi_axi_demux_wr.sv
// taxi_axi_demux_wr: AXI4 write demux routing one slave port to M_COUNT masters by address decode
module taxi_axi_demux_wr #(
  parameter int M_COUNT = 4,
  parameter int ADDR_W = 32,
  parameter int M_REGIONS = 1,
  parameter logic [M_COUNT*M_REGIONS*ADDR_W-1:0] M_BASE_ADDR = '0,
  parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_W = {M_COUNT{{M_REGIONS{32'd24}}}},
  parameter logic [M_COUNT-1:0] M_SECURE = {M_COUNT{1'b0}},
  parameter int MAX_OUTSTANDING = 16
) (
  input logic clk,
  input logic rst,
  taxi_axi_if.wr_slv s_axi_wr,
  taxi_axi_if.wr_mst m_axi_wr[M_COUNT]
);
  localparam int ID_W = s_axi_wr.ID_W;
  localparam int AWUSER_W = s_axi_wr.AWUSER_W;
  localparam int BUSER_W = s_axi_wr.BUSER_W;
  localparam int AWW = ID_W + ADDR_W + 29 + AWUSER_W;
  localparam int TW = $clog2(M_COUNT + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] ERR = TW'(M_COUNT);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
  function automatic logic hit(input int i, input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    logic [ADDR_W-1:0] b;
    hit = 1'b0;
    for (int r = 0; r < M_REGIONS; r++) begin
      w = M_ADDR_W[(i*M_REGIONS+r)*32 +: 32];
      b = M_BASE_ADDR == '0 ? ADDR_W'(i) << w : M_BASE_ADDR[(i*M_REGIONS+r)*ADDR_W +: ADDR_W];
      hit = hit | (w != 0 && (a >> w) == (b >> w));
    end
  endfunction
  logic [TW-1:0] dec_t, aw_t, cur, head;
  logic [AWW-1:0] aw_d, aw_q;
  logic aw_v, aw_acc, b_hs, w_pop, f_ne, eb_v;
  logic [ID_W-1:0] eb_id;
  logic [CW-1:0] cnt, fc;
  logic [PW-1:0] wp, rp;
  logic [TW-1:0] fq_t [MAX_OUTSTANDING];
  logic [ID_W-1:0] fq_id [MAX_OUTSTANDING];
  logic [M_COUNT:0] m_awready, m_wready, m_bvalid;
  logic [ID_W-1:0] m_bid [M_COUNT+1];
  logic [1:0] m_bresp [M_COUNT+1];
  logic [BUSER_W-1:0] m_buser [M_COUNT+1];
  always_comb begin
    dec_t = ERR;
    for (int i = M_COUNT - 1; i >= 0; i--)
      if (hit(i, s_axi_wr.awaddr)) dec_t = M_SECURE[i] && s_axi_wr.awprot[1] ? ERR : TW'(i);
  end
  assign aw_d = {s_axi_wr.awid, s_axi_wr.awaddr, s_axi_wr.awlen, s_axi_wr.awsize, s_axi_wr.awburst,
                 s_axi_wr.awlock, s_axi_wr.awcache, s_axi_wr.awprot, s_axi_wr.awqos, s_axi_wr.awregion,
                 s_axi_wr.awuser};
  assign s_axi_wr.awready = (!aw_v || m_awready[aw_t]) && cnt < CW'(MAX_OUTSTANDING) && (cnt == '0 || dec_t == cur);
  assign aw_acc = s_axi_wr.awvalid && s_axi_wr.awready;
  assign f_ne = fc != '0;
  assign head = fq_t[rp];
  assign s_axi_wr.wready = f_ne && m_wready[head];
  assign w_pop = s_axi_wr.wvalid && s_axi_wr.wready && s_axi_wr.wlast;
  assign s_axi_wr.bvalid = cnt != '0 && m_bvalid[cur];
  assign s_axi_wr.bid = m_bid[cur];
  assign s_axi_wr.bresp = m_bresp[cur];
  assign s_axi_wr.buser = m_buser[cur];
  assign b_hs = s_axi_wr.bvalid && s_axi_wr.bready;
  assign m_awready[M_COUNT] = 1'b1;
  assign m_wready[M_COUNT] = !eb_v;
  assign m_bvalid[M_COUNT] = eb_v;
  assign m_bid[M_COUNT] = eb_id;
  assign m_bresp[M_COUNT] = 2'b11;
  assign m_buser[M_COUNT] = '0;
  for (genvar i = 0; i < M_COUNT; i++) begin : g_m
    assign {m_axi_wr[i].awid, m_axi_wr[i].awaddr, m_axi_wr[i].awlen, m_axi_wr[i].awsize, m_axi_wr[i].awburst,
            m_axi_wr[i].awlock, m_axi_wr[i].awcache, m_axi_wr[i].awprot, m_axi_wr[i].awqos, m_axi_wr[i].awregion,
            m_axi_wr[i].awuser} = aw_q;
    assign m_axi_wr[i].awvalid = aw_v && aw_t == TW'(i);
    assign m_axi_wr[i].wdata = s_axi_wr.wdata;
    assign m_axi_wr[i].wstrb = s_axi_wr.wstrb;
    assign m_axi_wr[i].wlast = s_axi_wr.wlast;
    assign m_axi_wr[i].wuser = s_axi_wr.wuser;
    assign m_axi_wr[i].wvalid = f_ne && head == TW'(i) && s_axi_wr.wvalid;
    assign m_axi_wr[i].bready = cnt != '0 && cur == TW'(i) && s_axi_wr.bready;
    assign m_awready[i] = m_axi_wr[i].awready;
    assign m_wready[i] = m_axi_wr[i].wready;
    assign m_bvalid[i] = m_axi_wr[i].bvalid;
    assign m_bid[i] = m_axi_wr[i].bid;
    assign m_bresp[i] = m_axi_wr[i].bresp;
    assign m_buser[i] = m_axi_wr[i].buser;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_v <= 1'b0;
      cnt <= '0;
      cur <= '0;
      fc <= '0;
      wp <= '0;
      rp <= '0;
      eb_v <= 1'b0;
    end else begin
      aw_v <= aw_acc || (aw_v && !m_awready[aw_t]);
      cnt <= cnt + CW'(aw_acc) - CW'(b_hs);
      fc <= fc + CW'(aw_acc) - CW'(w_pop);
      eb_v <= (w_pop && head == ERR) || (eb_v && !(b_hs && cur == ERR));
      if (aw_acc) cur <= dec_t;
      if (aw_acc) wp <= wp == LAST ? '0 : wp + 1'b1;
      if (w_pop) rp <= rp == LAST ? '0 : rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (aw_acc) begin
      aw_q <= aw_d;
      aw_t <= dec_t;
      fq_t[wp] <= dec_t;
      fq_id[wp] <= s_axi_wr.awid;
    end
    if (w_pop && head == ERR) eb_id <= fq_id[rp];
  end
endmodule

// File: tb/tb_taxi_axi_demux_wr.sv
// tb_taxi_axi_demux_wr: directed checks of write decode, routing, DECERR, ordering stalls and reset
module tb_taxi_axi_demux_wr;
  logic clk = 1'b0;
  logic rst;
  int vec = 0;
  int miss = 0;
  always #5 clk = ~clk;
  taxi_axi_if s_if ();
  taxi_axi_if m_if[4] ();
  logic [3:0] m_awready, m_wready, m_bvalid;
  logic [7:0] m_bid [4];
  logic [1:0] m_bresp [4];
  logic [3:0] m_awvalid, m_wvalid, m_wlast, m_bready;
  logic [31:0] m_awaddr [4];
  logic [7:0] m_awid [4];
  logic [7:0] m_awlen [4];
  logic [31:0] m_wdata [4];
  for (genvar i = 0; i < 4; i++) begin : g_m
    assign m_if[i].awready = m_awready[i];
    assign m_if[i].wready = m_wready[i];
    assign m_if[i].bvalid = m_bvalid[i];
    assign m_if[i].bid = m_bid[i];
    assign m_if[i].bresp = m_bresp[i];
    assign m_if[i].buser = 1'b0;
    assign m_awvalid[i] = m_if[i].awvalid;
    assign m_wvalid[i] = m_if[i].wvalid;
    assign m_wlast[i] = m_if[i].wlast;
    assign m_bready[i] = m_if[i].bready;
    assign m_awaddr[i] = m_if[i].awaddr;
    assign m_awid[i] = m_if[i].awid;
    assign m_awlen[i] = m_if[i].awlen;
    assign m_wdata[i] = m_if[i].wdata;
  end
  taxi_axi_demux_wr #(.M_COUNT(4), .MAX_OUTSTANDING(2), .M_SECURE(4'b0010)) dut (
    .clk(clk),
    .rst(rst),
    .s_axi_wr(s_if),
    .m_axi_wr(m_if)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic aw(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len, input logic [2:0] prot);
    s_if.awaddr = a;
    s_if.awid = id;
    s_if.awlen = len;
    s_if.awprot = prot;
    s_if.awvalid = 1'b1;
  endtask
  task automatic beat(input logic [31:0] d, input logic last);
    s_if.wdata = d;
    s_if.wlast = last;
    s_if.wvalid = 1'b1;
  endtask
  task automatic wdone();
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = 3'd2; s_if.awburst = 2'b01;
    s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awregion = '0;
    s_if.awuser = '0; s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = 4'hF; s_if.wlast = 1'b0;
    s_if.wuser = '0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
    m_awready = 4'hF; m_wready = 4'hF; m_bvalid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_bid[i] = '0;
      m_bresp[i] = '0;
    end
    tick();
    tick();
    chk("rst_awready", s_if.awready, 1);
    chk("rst_wready", s_if.wready, 0);
    chk("rst_bvalid", s_if.bvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    rst = 1'b0;
    aw(32'h0100_0010, 8'h5A, 8'd3, 3'b000);
    #1 chk("t1_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat(32'hA000 + b, b == 3);
      #1;
      if (b == 0) begin
        chk("t1_m_awvalid", m_awvalid, 4'b0010);
        chk("t1_m_awaddr", m_awaddr[1], 32'h0100_0010);
        chk("t1_m_awid", m_awid[1], 8'h5A);
        chk("t1_m_awlen", m_awlen[1], 8'd3);
      end
      if (b == 1) chk("t1_m_awvalid_drop", m_awvalid, 0);
      chk("t1_m_wvalid", m_wvalid, 4'b0010);
      chk("t1_m_wdata", m_wdata[1], 32'hA000 + b);
      chk("t1_m_wlast", m_wlast[1], b == 3);
      chk("t1_s_wready", s_if.wready, 1);
      tick();
    end
    wdone();
    #1 chk("t1_wready_idle", s_if.wready, 0);
    m_bvalid[1] = 1'b1; m_bid[1] = 8'h5A; m_bresp[1] = 2'b00; s_if.bready = 1'b1;
    #1 chk("t1_bvalid", s_if.bvalid, 1);
    chk("t1_bid", s_if.bid, 8'h5A);
    chk("t1_bresp", s_if.bresp, 2'b00);
    chk("t1_m_bready", m_bready, 4'b0010);
    tick();
    m_bvalid[1] = 1'b0;
    #1 chk("t1_bvalid_done", s_if.bvalid, 0);
    aw(32'h0400_0000, 8'h33, 8'd1, 3'b000);
    #1 chk("t2_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    beat(32'h1, 1'b0);
    #1 chk("t2_m_awvalid", m_awvalid, 0);
    chk("t2_m_wvalid", m_wvalid, 0);
    chk("t2_wready0", s_if.wready, 1);
    tick();
    s_if.wlast = 1'b1;
    #1 chk("t2_wready1", s_if.wready, 1);
    tick();
    wdone();
    #1 chk("t2_bvalid", s_if.bvalid, 1);
    chk("t2_bresp", s_if.bresp, 2'b11);
    chk("t2_bid", s_if.bid, 8'h33);
    chk("t2_m_bready", m_bready, 0);
    tick();
    #1 chk("t2_bvalid_done", s_if.bvalid, 0);
    s_if.bready = 1'b0;
    aw(32'h0000_0100, 8'h01, 8'd0, 3'b000);
    #1 chk("t3_aw1_ready", s_if.awready, 1);
    tick();
    aw(32'h0200_0000, 8'h02, 8'd0, 3'b000);
    #1 chk("t3_aw2_blocked", s_if.awready, 0);
    chk("t3_m0_awvalid", m_awvalid, 4'b0001);
    beat(32'hB0, 1'b1);
    #1 chk("t3_m0_wvalid", m_wvalid, 4'b0001);
    tick();
    wdone();
    #1 chk("t3_aw2_still_blocked", s_if.awready, 0);
    m_bvalid[0] = 1'b1; m_bid[0] = 8'h01; s_if.bready = 1'b1;
    #1 chk("t3_b0_valid", s_if.bvalid, 1);
    chk("t3_b0_id", s_if.bid, 8'h01);
    chk("t3_m_bready", m_bready, 4'b0001);
    chk("t3_aw2_blocked_at_b", s_if.awready, 0);
    tick();
    m_bvalid[0] = 1'b0;
    #1 chk("t3_aw2_ready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    #1 chk("t3_m2_awvalid", m_awvalid, 4'b0100);
    chk("t3_m2_awid", m_awid[2], 8'h02);
    beat(32'hB1, 1'b1);
    #1 chk("t3_m2_wvalid", m_wvalid, 4'b0100);
    tick();
    wdone();
    m_bvalid[2] = 1'b1; m_bid[2] = 8'h02;
    #1 chk("t3_b2_id", s_if.bid, 8'h02);
    chk("t3_m2_bready", m_bready, 4'b0100);
    tick();
    m_bvalid[2] = 1'b0;
    s_if.bready = 1'b0;
    aw(32'h0300_0000, 8'h31, 8'd0, 3'b000);
    #1 chk("t4_aw1_ready", s_if.awready, 1);
    tick();
    aw(32'h0300_0040, 8'h32, 8'd0, 3'b000);
    #1 chk("t4_aw2_ready", s_if.awready, 1);
    tick();
    aw(32'h0300_0080, 8'h33, 8'd0, 3'b000);
    #1 chk("t4_aw3_stall", s_if.awready, 0);
    beat(32'hC0, 1'b1);
    tick();
    tick();
    wdone();
    #1 chk("t4_aw3_stall_after_w", s_if.awready, 0);
    m_bvalid[3] = 1'b1; m_bid[3] = 8'h31; s_if.bready = 1'b1;
    #1 chk("t4_b1_valid", s_if.bvalid, 1);
    chk("t4_b1_id", s_if.bid, 8'h31);
    chk("t4_aw3_stall_at_b", s_if.awready, 0);
    tick();
    m_bvalid[3] = 1'b0;
    #1 chk("t4_aw3_ready", s_if.awready, 1);
    tick();
    aw(32'h0300_00C0, 8'h34, 8'd0, 3'b000);
    #1 chk("t4_cnt_full", s_if.awready, 0);
    s_if.awvalid = 1'b0;
    beat(32'hC1, 1'b1);
    #1 chk("t4_m3_wvalid", m_wvalid, 4'b1000);
    tick();
    wdone();
    m_bvalid[3] = 1'b1; m_bid[3] = 8'h32;
    #1 chk("t4_b2_id", s_if.bid, 8'h32);
    tick();
    m_bid[3] = 8'h33;
    #1 chk("t4_b3_id", s_if.bid, 8'h33);
    tick();
    m_bvalid[3] = 1'b0;
    #1 chk("t4_bvalid_done", s_if.bvalid, 0);
    aw(32'h0100_0000, 8'h40, 8'd0, 3'b010);
    #1 chk("t5_sec_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    beat(32'hD0, 1'b1);
    #1 chk("t5_sec_m_awvalid", m_awvalid, 0);
    chk("t5_sec_m_wvalid", m_wvalid, 0);
    chk("t5_sec_wready", s_if.wready, 1);
    tick();
    wdone();
    #1 chk("t5_sec_bvalid", s_if.bvalid, 1);
    chk("t5_sec_bresp", s_if.bresp, 2'b11);
    chk("t5_sec_bid", s_if.bid, 8'h40);
    tick();
    aw(32'h0100_0000, 8'h41, 8'd0, 3'b000);
    #1 chk("t5_ns_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    #1 chk("t5_ns_m_awvalid", m_awvalid, 4'b0010);
    beat(32'hD1, 1'b1);
    #1 chk("t5_ns_m_wvalid", m_wvalid, 4'b0010);
    tick();
    wdone();
    m_bvalid[1] = 1'b1; m_bid[1] = 8'h41; m_bresp[1] = 2'b00;
    #1 chk("t5_ns_bresp", s_if.bresp, 2'b00);
    chk("t5_ns_bid", s_if.bid, 8'h41);
    tick();
    m_bvalid[1] = 1'b0;
    aw(32'h0200_0000, 8'h50, 8'd3, 3'b000);
    tick();
    s_if.awvalid = 1'b0;
    beat(32'hE0, 1'b0);
    #1 chk("t6_beat1_wvalid", m_wvalid, 4'b0100);
    tick();
    s_if.wdata = 32'hE1;
    rst = 1'b1;
    tick();
    chk("t6_rst_wready", s_if.wready, 0);
    chk("t6_rst_m_wvalid", m_wvalid, 0);
    chk("t6_rst_m_awvalid", m_awvalid, 0);
    chk("t6_rst_awready", s_if.awready, 1);
    chk("t6_rst_bvalid", s_if.bvalid, 0);
    rst = 1'b0;
    wdone();
    aw(32'h0200_0000, 8'h51, 8'd0, 3'b000);
    #1 chk("t6_new_awready", s_if.awready, 1);
    tick();
    s_if.awvalid = 1'b0;
    #1 chk("t6_new_m_awvalid", m_awvalid, 4'b0100);
    chk("t6_new_m_awid", m_awid[2], 8'h51);
    beat(32'hE2, 1'b1);
    #1 chk("t6_new_m_wvalid", m_wvalid, 4'b0100);
    chk("t6_new_m_wlast", m_wlast[2], 1);
    tick();
    wdone();
    m_bvalid[2] = 1'b1; m_bid[2] = 8'h51;
    #1 chk("t6_new_bvalid", s_if.bvalid, 1);
    chk("t6_new_bid", s_if.bid, 8'h51);
    tick();
    m_bvalid[2] = 1'b0;
    #1 chk("t6_new_bvalid_done", s_if.bvalid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
